ahb_slave_responder: RTL and testbench

AHB-Lite slave responder terminating one slave port of the AHB interconnect. It decodes address and data phases, services transfers from an internal word-addressed memory, inserts programmable wait states and generates the two-cycle ERROR response. One instance sits on each `ahbSlaveInterface` port. It is the target-side counterpart of the interconnect's master-side arbitration and routing.

---
 rtl/ahb_slave_responder.sv | 148 ++++++++++++++
 tb/tb_ahb_slave_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_responder.sv
// AHB-Lite slave responder: word memory behind one slave port with a two-cycle ERROR response.
// Wait states are built only when AHB_SLV_WAIT_EN is defined; otherwise every OKAY data phase is single-cycle.
module ahb_slave_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 2
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hreadyout,
  output logic                  hresp
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * STRB_W);

  // IDLE: no data phase | WAIT: stalling | DATA: OKAY data phase | ERR1/ERR2: two-cycle ERROR
`ifdef AHB_SLV_WAIT_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);
`else
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_ERR1, S_ERR2} state_t;
`endif

  state_t state_q, state_d, launch;

  logic                  accept;
  logic                  addr_err;
  logic [ADDR_WIDTH-1:0] offset;
  logic [7:0]            align_mask;

  logic [IDX_W-1:0]      idx_q;
  logic [LANE_W-1:0]     lane_q;
  logic [2:0]            size_q;
  logic                  write_q;
  logic [STRB_W-1:0]     be;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  assign accept     = hselx & hready & htrans[1];
  assign offset     = haddr - BASE_ADDR;
  assign align_mask = (8'd1 << hsize) - 8'd1;

  always_comb begin
    addr_err = (haddr < BASE_ADDR)
            || ({1'b0, offset} >= MEM_BYTES)
            || (|(haddr[7:0] & align_mask))
            || (hsize > 3'(LANE_W));
  end

  // Address phase is only captured while this slave is itself ready, so a stalled phase is never overwritten.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else if (accept && hreadyout) begin
      idx_q   <= offset[LANE_W +: IDX_W];
      lane_q  <= offset[LANE_W-1:0];
      size_q  <= hsize;
      write_q <= hwrite;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

`ifdef AHB_SLV_WAIT_EN
  logic [3:0] wait_cnt;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                                   wait_cnt <= '0;
    else if (state_q != S_WAIT && state_d == S_WAIT) wait_cnt <= WAIT_LOAD;
    else if (state_q == S_WAIT && wait_cnt != 4'd0)  wait_cnt <= wait_cnt - 4'd1;
  end
`endif

  always_comb begin
    if (!accept)       launch = S_IDLE;
    else if (addr_err) launch = S_ERR1;
    else               launch = S_DATA;
`ifdef AHB_SLV_WAIT_EN
    if (accept && !addr_err && WAIT_STATES > 0) launch = S_WAIT;
`endif
  end

  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      S_IDLE: state_d = launch;
`ifdef AHB_SLV_WAIT_EN
      S_WAIT: begin
        hreadyout = 1'b0;
        if (wait_cnt == 4'd0) state_d = S_DATA;
      end
`endif
      S_DATA: state_d = launch;
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        hresp   = 1'b1;
        state_d = launch;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Little-endian lane enables from the registered size and low address bits.
  always_comb begin
    be = '0;
    for (int b = 0; b < STRB_W; b++)
      be[b] = (b >= int'(lane_q)) && (b < int'(lane_q) + (1 << size_q));
  end

  always_ff @(posedge hclk) begin
    if (state_q == S_DATA && write_q) begin
      for (int b = 0; b < STRB_W; b++)
        if (be[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
    end
  end

  assign hrdata = (state_q == S_DATA && !write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Directed bench for ahb_slave_responder; expected wait count follows AHB_SLV_WAIT_EN.
module tb_ahb_slave_responder;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef AHB_SLV_WAIT_EN
  localparam int EXP_W = 2;
`else
  localparam int EXP_W = 0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        hselx = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd2;
  logic [2:0]  hburst = 3'd0;
  logic [31:0] hwdata = '0;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;

  int tests = 0;
  int fails = 0;

  assign hready = hreadyout;

  always #5 hclk = ~hclk;

  ahb_slave_responder #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MEM_DEPTH  (256),
    .BASE_ADDR  (BASE),
    .WAIT_STATES(2)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hselx    (hselx),
    .haddr    (haddr),
    .htrans   (htrans),
    .hwrite   (hwrite),
    .hsize    (hsize),
    .hburst   (hburst),
    .hwdata   (hwdata),
    .hready   (hready),
    .hrdata   (hrdata),
    .hreadyout(hreadyout),
    .hresp    (hresp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Single non-pipelined transfer from an idle bus; reports stall cycles, ERROR seen and read data.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output int waits, output logic err);
    hselx = 1'b1; haddr = a; htrans = 2'b10; hwrite = wr; hsize = sz;
    tick();
    hselx = 1'b0; htrans = 2'b00; hwdata = wd;
    waits = 0; err = 1'b0;
    while (hreadyout !== 1'b1 && waits < 20) begin
      if (hresp === 1'b1) err = 1'b1;
      waits++;
      tick();
    end
    rd = hrdata;
    if (hresp === 1'b1) err = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          w;
    logic        e;

    #3;
    chk("rst_async_ready", hreadyout, 1);
    chk("rst_async_resp", hresp, 0);
    chk("rst_async_rdata", hrdata, 0);
    tick(); tick();
    hresetn = 1'b1;
    tick(); tick();
    chk("idle_ready", hreadyout, 1);
    chk("idle_resp", hresp, 0);
    chk("idle_rdata", hrdata, 0);

    // IDLE and BUSY transfers with hselx=1 start nothing
    hselx = 1'b1; haddr = BASE + 32'h10; htrans = 2'b00; hwrite = 1'b0;
    tick();
    chk("idle_tr_ready", hreadyout, 1);
    htrans = 2'b01;
    tick();
    chk("busy_tr_ready", hreadyout, 1);
    chk("busy_tr_resp", hresp, 0);
    chk("busy_tr_rdata", hrdata, 0);
    hselx = 1'b0; htrans = 2'b00;
    tick();

    xfer(1, BASE + 32'h10, 3'd2, 32'hDEAD_BEEF, rd, w, e);
    chk("wr_word_wait", w, EXP_W);
    chk("wr_word_err", e, 0);
    xfer(0, BASE + 32'h10, 3'd2, 32'h0, rd, w, e);
    chk("rd_word_wait", w, EXP_W);
    chk("rd_word_err", e, 0);
    chk("rd_word_data", rd, 32'hDEAD_BEEF);

    xfer(1, BASE + 32'h10, 3'd2, 32'h1122_3344, rd, w, e);
    xfer(1, BASE + 32'h13, 3'd0, 32'hA500_0000, rd, w, e);
    chk("wr_byte_err", e, 0);
    xfer(0, BASE + 32'h10, 3'd2, 32'h0, rd, w, e);
    chk("rd_after_byte", rd, 32'hA522_3344);
    xfer(1, BASE + 32'h12, 3'd1, 32'hBEEF_0000, rd, w, e);
    xfer(0, BASE + 32'h10, 3'd2, 32'h0, rd, w, e);
    chk("rd_after_half", rd, 32'hBEEF_3344);

    // out-of-range read: exact ERR1/ERR2 cycle values
    hselx = 1'b1; haddr = BASE + 32'h400; htrans = 2'b10; hwrite = 1'b0; hsize = 3'd2;
    tick();
    hselx = 1'b0; htrans = 2'b00;
    chk("err1_ready", hreadyout, 0);
    chk("err1_resp", hresp, 1);
    tick();
    chk("err2_ready", hreadyout, 1);
    chk("err2_resp", hresp, 1);
    chk("err2_rdata", hrdata, 0);
    tick();
    chk("post_err_resp", hresp, 0);

    xfer(1, BASE + 32'h3FC, 3'd2, 32'h5A5A_0FF0, rd, w, e);
    chk("last_wr_err", e, 0);
    xfer(0, BASE + 32'h3FC, 3'd2, 32'h0, rd, w, e);
    chk("last_rd_err", e, 0);
    chk("last_rd_wait", w, EXP_W);
    chk("last_rd_data", rd, 32'h5A5A_0FF0);

    xfer(1, BASE + 32'h0, 3'd2, 32'h0BAD_F00D, rd, w, e);
    xfer(1, BASE + 32'h1, 3'd1, 32'hFFFF_FFFF, rd, w, e);
    chk("misalign_err", e, 1);
    chk("misalign_len", w, 1);
    xfer(0, BASE + 32'h0, 3'd2, 32'h0, rd, w, e);
    chk("misalign_nowrite", rd, 32'h0BAD_F00D);

    xfer(0, BASE - 32'h4, 3'd2, 32'h0, rd, w, e);
    chk("below_base_err", e, 1);
    chk("below_base_len", w, 1);
    xfer(1, BASE + 32'h20, 3'd3, 32'h1234_5678, rd, w, e);
    chk("oversize_err", e, 1);

    // write then read of the same word, read address presented during the write data phase
    hselx = 1'b1; haddr = BASE + 32'h80; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    tick();
    hwdata = 32'hCAFE_F00D; hwrite = 1'b0;
    w = 0;
    while (hreadyout !== 1'b1 && w < 20) begin w++; tick(); end
    chk("b2b_wr_wait", w, EXP_W);
    chk("b2b_wr_rdata0", hrdata, 0);
    tick();
    hselx = 1'b0; htrans = 2'b00;
    w = 0;
    while (hreadyout !== 1'b1 && w < 20) begin w++; tick(); end
    chk("b2b_rd_wait", w, EXP_W);
    chk("b2b_rd_data", hrdata, 32'hCAFE_F00D);
    tick();

    // reset in the middle of a write data phase
    xfer(1, BASE + 32'h40, 3'd2, 32'h1234_5678, rd, w, e);
    hselx = 1'b1; haddr = BASE + 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
    tick();
    hselx = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_0000;
    chk("mid_ready", hreadyout, (EXP_W > 0) ? 1'b0 : 1'b1);
    #2 hresetn = 1'b0;
    #1;
    chk("mid_rst_ready", hreadyout, 1);
    chk("mid_rst_resp", hresp, 0);
    chk("mid_rst_rdata", hrdata, 0);
    tick(); tick();
    hresetn = 1'b1;
    tick();
    xfer(0, BASE + 32'h40, 3'd2, 32'h0, rd, w, e);
    chk("mid_rst_old_data", rd, 32'h1234_5678);
    chk("mid_rst_rd_wait", w, EXP_W);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
